// File: rtl/pipe_buffer.sv
// Elastic pipeline register: a DEPTH-entry in-order buffer with valid/ready on both sides,
// a flush path, and a saturating counter of beats discarded by flush.
module pipe_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         valid_i,
    input  logic [DATA_W-1:0]            data_i,
    output logic                         ready_o,
    output logic                         valid_o,
    output logic [DATA_W-1:0]            data_o,
    input  logic                         ready_i,
    input  logic                         flush_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic [CNT_W-1:0]             flushed_cnt_o
);

    localparam int CW    = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // A one-entry buffer still needs a 1-bit pointer, so it gets a second, never-used slot.
    localparam int MEM_N = (DEPTH < 2) ? 2 : DEPTH;
    localparam int SUM_W = ((CNT_W > CW) ? CNT_W : CW) + 1;

    logic [DATA_W-1:0] mem [MEM_N];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CW-1:0]     count;
    logic [CNT_W-1:0]  flushed_cnt;

    logic              acc;
    logic              pop;
    logic [SUM_W-1:0]  flush_add;
    logic [SUM_W-1:0]  flush_sum;
    logic              flush_sat;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Handshake: a beat moves on a side only in a cycle where both valid and ready are high
    // at the rising edge; flush suppresses both transfers. ready_o and valid_o depend only on
    // the registered count, so neither side sees a combinational path from the other.
    assign ready_o = (count < CW'(DEPTH));
    assign valid_o = (count != '0);
    assign acc     = valid_i & ready_o & ~flush_i;
    assign pop     = valid_o & ready_i & ~flush_i;

    assign data_o        = mem[head];
    assign count_o       = count;
    assign flushed_cnt_o = flushed_cnt;

    // Discarded beats are everything stored plus a beat that would have been accepted.
    assign flush_add = SUM_W'(count) + SUM_W'(valid_i & ready_o);
    assign flush_sum = SUM_W'(flushed_cnt) + flush_add;
    assign flush_sat = (flush_sum > SUM_W'({CNT_W{1'b1}}));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            flushed_cnt <= '0;
        end else if (flush_i) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            flushed_cnt <= flush_sat ? {CNT_W{1'b1}} : flush_sum[CNT_W-1:0];
        end else begin
            if (acc) begin
                tail <= next_ptr(tail);
            end
            if (pop) begin
                head <= next_ptr(head);
            end
            count <= count + CW'(acc) - CW'(pop);
        end
    end

    // Storage is zeroed only by reset; flush leaves contents in place.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < MEM_N; i++) begin
                mem[i] <= '0;
            end
        end else if (acc) begin
            mem[tail] <= data_i;
        end
    end

endmodule

// File: tb/tb_pipe_buffer.sv
// Bench for pipe_buffer: vector table on a DEPTH=2 instance, hand sequences on DEPTH=1 and
// DEPTH=3/CNT_W=2 instances, and a random soak against a queue model.
module tb_pipe_buffer;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DEPTH=2 instance
    logic       a_valid, a_ready_i, a_flush, a_ready_o, a_valid_o;
    logic [7:0] a_data, a_dout;
    logic [1:0] a_count;
    logic [15:0] a_fcnt;
    // DEPTH=1 instance
    logic       b_valid, b_ready_i, b_flush, b_ready_o, b_valid_o;
    logic [7:0] b_data, b_dout;
    logic [0:0] b_count;
    logic [15:0] b_fcnt;
    // DEPTH=3, CNT_W=2 instance
    logic       c_valid, c_ready_i, c_flush, c_ready_o, c_valid_o;
    logic [7:0] c_data, c_dout;
    logic [1:0] c_count;
    logic [1:0] c_fcnt;

    pipe_buffer #(.DATA_W(8), .DEPTH(2), .CNT_W(16)) u_a (
        .clk_i(clk), .reset_i(rst), .valid_i(a_valid), .data_i(a_data), .ready_o(a_ready_o),
        .valid_o(a_valid_o), .data_o(a_dout), .ready_i(a_ready_i), .flush_i(a_flush),
        .count_o(a_count), .flushed_cnt_o(a_fcnt));

    pipe_buffer #(.DATA_W(8), .DEPTH(1), .CNT_W(16)) u_b (
        .clk_i(clk), .reset_i(rst), .valid_i(b_valid), .data_i(b_data), .ready_o(b_ready_o),
        .valid_o(b_valid_o), .data_o(b_dout), .ready_i(b_ready_i), .flush_i(b_flush),
        .count_o(b_count), .flushed_cnt_o(b_fcnt));

    pipe_buffer #(.DATA_W(8), .DEPTH(3), .CNT_W(2)) u_c (
        .clk_i(clk), .reset_i(rst), .valid_i(c_valid), .data_i(c_data), .ready_o(c_ready_o),
        .valid_o(c_valid_o), .data_o(c_dout), .ready_i(c_ready_i), .flush_i(c_flush),
        .count_o(c_count), .flushed_cnt_o(c_fcnt));

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        r;
        logic        f;
        logic        e_valid;
        logic        e_ready;
        logic [1:0]  e_count;
        logic        chk_data;
        logic [7:0]  e_data;
        logic [15:0] e_fcnt;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: scoreboard empty, got an unexpected beat", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_q[$];
    int         sat_exp[3];
    int         delivered;
    int         bm;
    int         mf;
    logic [7:0] next_d;
    logic       m_acc;
    logic       m_ready;
    logic       pend;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0;
        {a_valid, a_ready_i, a_flush, a_data} = '0;
        {b_valid, b_ready_i, b_flush, b_data} = '0;
        {c_valid, c_ready_i, c_flush, c_data} = '0;

        // ---------------- reset values ----------------
        #1 rst = 1'b1;
        #1;
        check("rst_a_valid", a_valid_o, 0);
        check("rst_a_ready", a_ready_o, 1);
        check("rst_a_data",  a_dout,    0);
        check("rst_a_count", a_count,   0);
        check("rst_a_fcnt",  a_fcnt,    0);
        check("rst_b_ready", b_ready_o, 1);
        check("rst_c_fcnt",  c_fcnt,    0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // ---------------- DEPTH=2 vector table ----------------
        //          v  d      r  f   ev er cnt  cd ed     fcnt
        vecs[0]  = '{1, 8'h11, 1, 0,  0, 1, 2'd0, 1, 8'h00, 16'd0};
        vecs[1]  = '{1, 8'h22, 1, 0,  1, 1, 2'd1, 1, 8'h11, 16'd0};
        vecs[2]  = '{1, 8'h33, 1, 0,  1, 1, 2'd1, 1, 8'h22, 16'd0};
        vecs[3]  = '{0, 8'h00, 1, 0,  1, 1, 2'd1, 1, 8'h33, 16'd0};
        vecs[4]  = '{0, 8'h00, 1, 0,  0, 1, 2'd0, 0, 8'h00, 16'd0};
        vecs[5]  = '{1, 8'h0A, 0, 0,  0, 1, 2'd0, 0, 8'h00, 16'd0};
        vecs[6]  = '{1, 8'h0B, 0, 0,  1, 1, 2'd1, 1, 8'h0A, 16'd0};
        vecs[7]  = '{1, 8'h0C, 0, 0,  1, 0, 2'd2, 1, 8'h0A, 16'd0};
        vecs[8]  = '{1, 8'h0C, 1, 0,  1, 0, 2'd2, 1, 8'h0A, 16'd0};
        vecs[9]  = '{1, 8'h0C, 1, 0,  1, 1, 2'd1, 1, 8'h0B, 16'd0};
        vecs[10] = '{0, 8'h00, 1, 0,  1, 1, 2'd1, 1, 8'h0C, 16'd0};
        vecs[11] = '{0, 8'h00, 0, 0,  0, 1, 2'd0, 0, 8'h00, 16'd0};
        vecs[12] = '{1, 8'h01, 0, 0,  0, 1, 2'd0, 0, 8'h00, 16'd0};
        vecs[13] = '{1, 8'h02, 0, 0,  1, 1, 2'd1, 1, 8'h01, 16'd0};
        vecs[14] = '{1, 8'h03, 0, 1,  1, 0, 2'd2, 1, 8'h01, 16'd0};
        vecs[15] = '{1, 8'h55, 1, 0,  0, 1, 2'd0, 0, 8'h00, 16'd2};
        vecs[16] = '{0, 8'h00, 1, 0,  1, 1, 2'd1, 1, 8'h55, 16'd2};
        vecs[17] = '{0, 8'h00, 1, 0,  0, 1, 2'd0, 0, 8'h00, 16'd2};

        for (int i = 0; i < 18; i++) begin
            a_valid   = vecs[i].v;
            a_data    = vecs[i].d;
            a_ready_i = vecs[i].r;
            a_flush   = vecs[i].f;
            #1;
            check($sformatf("vec%0d_valid", i), a_valid_o, vecs[i].e_valid);
            check($sformatf("vec%0d_ready", i), a_ready_o, vecs[i].e_ready);
            check($sformatf("vec%0d_count", i), a_count,   vecs[i].e_count);
            check($sformatf("vec%0d_fcnt", i),  a_fcnt,    vecs[i].e_fcnt);
            if (vecs[i].chk_data) begin
                check($sformatf("vec%0d_data", i), a_dout, vecs[i].e_data);
            end
            tick();
        end
        a_valid = 1'b0;
        a_flush = 1'b0;

        // ---------------- DEPTH=1 half throughput ----------------
        b_ready_i = 1'b1;
        next_d    = 8'h40;
        delivered = 0;
        bm        = 0;
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            b_valid = 1'b1;
            b_data  = next_d;
            #1;
            check($sformatf("d1_ready_c%0d", i), b_ready_o, (i % 2) == 0);
            check($sformatf("d1_valid_c%0d", i), b_valid_o, bm == 1);
            if (b_valid_o) begin
                delivered++;
                if (exp_q.size() != 0) check("d1_data", b_dout, exp_q.pop_front());
                else note_fail("d1_data");
            end
            m_acc = (bm == 0);
            if (m_acc) exp_q.push_back(next_d);
            tick();
            bm = m_acc ? 1 : 0;
            if (m_acc) next_d = next_d + 8'd1;
        end
        b_valid = 1'b0;
        check("d1_delivered", delivered, 4);
        tick();

        // ---------------- DEPTH=3, CNT_W=2: flush counter saturation ----------------
        sat_exp[0] = 2;
        sat_exp[1] = 3;
        sat_exp[2] = 3;
        for (int k = 0; k < 3; k++) begin
            c_ready_i = 1'b0;
            c_flush   = 1'b0;
            c_valid   = 1'b1;
            c_data    = 8'(2 * k + 1);
            tick();
            c_data    = 8'(2 * k + 2);
            tick();
            c_valid   = 1'b0;
            check($sformatf("sat%0d_pre_count", k), c_count, 2);
            c_flush   = 1'b1;
            tick();
            c_flush   = 1'b0;
            check($sformatf("sat%0d_fcnt", k),  c_fcnt,    sat_exp[k]);
            check($sformatf("sat%0d_count", k), c_count,   0);
            check($sformatf("sat%0d_valid", k), c_valid_o, 0);
            check($sformatf("sat%0d_ready", k), c_ready_o, 1);
        end

        // ---------------- asynchronous reset mid-stream ----------------
        c_valid = 1'b1;
        c_data  = 8'h77;
        tick();
        c_valid = 1'b0;
        check("mid_pre_count", c_count, 1);
        check("mid_pre_data",  c_dout,  8'h77);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", c_valid_o, 0);
        check("mid_rst_ready", c_ready_o, 1);
        check("mid_rst_data",  c_dout,    0);
        check("mid_rst_fcnt",  c_fcnt,    0);
        check("mid_rst_count", c_count,   0);
        @(posedge clk);
        #1 rst = 1'b0;

        // ---------------- flush with count=2 and a beat presented ----------------
        c_valid = 1'b1;
        c_data  = 8'hE1;
        tick();
        c_data  = 8'hE2;
        tick();
        check("fl_head_entry0", c_dout, 8'hE1);
        c_data  = 8'hE3;
        c_flush = 1'b1;
        tick();
        c_flush = 1'b0;
        check("fl_fcnt",  c_fcnt,    3);
        check("fl_count", c_count,   0);
        check("fl_valid", c_valid_o, 0);
        check("fl_ready", c_ready_o, 1);
        c_data  = 8'h55;
        tick();
        c_valid = 1'b0;
        check("fl_next_valid", c_valid_o, 1);
        check("fl_next_data",  c_dout,    8'h55);
        check("fl_next_count", c_count,   1);

        // ---------------- random soak on DEPTH=3 ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        mf   = 0;
        pend = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            if (!pend) begin
                c_valid = 1'($urandom_range(0, 1));
                c_data  = 8'($urandom_range(0, 255));
            end
            c_ready_i = 1'($urandom_range(0, 1));
            c_flush   = ($urandom_range(0, 99) < 2);
            #1;
            check("soak_count", c_count,   exp_q.size());
            check("soak_ready", c_ready_o, exp_q.size() < 3);
            check("soak_valid", c_valid_o, exp_q.size() > 0);
            check("soak_fcnt",  c_fcnt,    mf);
            m_ready = (exp_q.size() < 3);
            m_acc   = c_valid && m_ready && !c_flush;
            if (c_flush) begin
                mf = mf + exp_q.size() + ((c_valid && m_ready) ? 1 : 0);
                if (mf > 3) mf = 3;
                exp_q.delete();
            end else begin
                if (exp_q.size() > 0 && c_ready_i) begin
                    check("soak_data", c_dout, exp_q.pop_front());
                end
                if (m_acc) exp_q.push_back(c_data);
            end
            pend = c_valid && !m_acc && !c_flush;
            tick();
        end
        c_valid = 1'b0;
        c_flush = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_buffer.md
# pipe_buffer

Parametrised elastic pipeline register for the stage-to-stage boundaries of the pipelined core. It replaces global stall/flush-driven stage flops with a DEPTH-entry in-order buffer and a valid/ready handshake on both sides. It keeps a flush path and a saturating discarded-beat counter for performance analysis. One instance sits between each pair of stages (fetch→decode, decode→execute, …); the payload is the concatenated stage bundle.

## Interface
- DATA_W, default 32: payload width in bits, minimum 1.
- DEPTH, default 2: number of entries, 1..4. DEPTH=1 gives half throughput; DEPTH≥2 gives full throughput.
- CNT_W, default 16: width of flushed_cnt_o.
- clk_i  input  1  clock; all state updates on its rising edge.
- reset_i  input  1  reset; asynchronous, active-high.
- valid_i  input  1  upstream beat present.
- data_i  input  DATA_W  upstream payload.
- ready_o  output  1  buffer can accept; asserted when count < DEPTH.
- valid_o  output  1  head entry present; asserted when count > 0.
- data_o  output  DATA_W  head entry payload.
- ready_i  input  1  downstream accepts the head.
- flush_i  input  1  discard all stored entries and any incoming beat.
- count_o  output  $clog2(DEPTH+1)  current occupancy.
- flushed_cnt_o  output  CNT_W  saturating count of beats discarded by flush.

## Operation
- Storage is a circular array of DEPTH entries, addressed by head and tail pointers that wrap at DEPTH. count is held explicitly.
- Accept: acc = valid_i & ready_o & ~flush_i. The beat is written at tail, and tail advances.
- Pop: pop = valid_o & ready_i & ~flush_i. head advances.
- count_next = count + acc − pop. When the buffer is full, pop and acc together are legal only if ready_o was already high, so a full buffer accepts nothing that cycle even if it pops.
- ready_o and valid_o are pure functions of registered count. There is no combinational path from ready_i to ready_o, or from valid_i to valid_o.
- data_o = storage[head] at all times. When valid_o=0 it shows a stale value, which is not checked beyond reset.
- Flush, which takes priority over everything else in the same cycle:
  - count, head and tail go to 0.
  - The incoming beat is dropped, and no pop is reported downstream.
  - flushed_cnt_o += count + (valid_i & ready_o), saturating at 2^CNT_W−1.
  - Storage contents are not cleared.
- Upstream protocol: while valid_i=1 and ready_o=0, the upstream holds data_i stable. The buffer does not check this.
- Order is strictly FIFO: no reordering and no duplication.

## Timing
- Reset values: valid_o=0, ready_o=1, data_o=0 (all storage zeroed), count_o=0, flushed_cnt_o=0, head=tail=0.
- Latency: a beat accepted at edge N is visible on valid_o/data_o after edge N. This is one cycle through an empty buffer.
- Throughput with downstream always ready: one beat per cycle for DEPTH≥2. For DEPTH=1 it is one beat every 2 cycles, because ready_o is low while the single entry is occupied.
- Full boundary: with count=DEPTH, ready_o=0. A pop at edge N raises ready_o after edge N.
- Empty boundary: with count=0, valid_o=0 and ready_i is ignored.
- Flush: after the flush edge, count=0, valid_o=0 and ready_o=1. A beat presented in the cycle after the flush is accepted normally.
- Reset asserted mid-operation: all outputs return to their reset values immediately (asynchronously). After reset deassertion the next accept lands at entry 0.
- Counter saturation: once flushed_cnt_o equals its all-ones value, it holds that value through further flushes.

## Test plan
- Streaming, DEPTH=2, ready_i=1: push 0x11,0x22,0x33 on consecutive cycles → valid_o first high one cycle after the first accept. data_o sequence is 0x11,0x22,0x33 on consecutive cycles, and ready_o never drops.
- Backpressure, DEPTH=2: push 0xA,0xB,0xC with ready_i=0 → count_o=2 and ready_o=0, so 0xC is held upstream. Then set ready_i=1 → outputs 0xA,0xB,0xC in order with no loss and no duplicates.
- DEPTH=1, ready_i=1: valid_i held high for 8 cycles → exactly 4 beats delivered, and ready_o alternates 1,0.
- Flush: with count=2 and valid_i=1 in the flush cycle → after the edge count_o=0, valid_o=0 and flushed_cnt_o=3. A beat 0x55 in the next cycle appears after one cycle.
- Saturation and reset: with CNT_W=2, repeated flushes of 2 entries give flushed_cnt_o 2,3,3. Asserting reset_i mid-stream with count=1 → valid_o=0, ready_o=1, data_o=0 and flushed_cnt_o=0 without waiting for a clock edge.
- Random soak, DEPTH=3: 10k cycles of random valid_i, ready_i and 2% flush, against a scoreboard queue model → identical output order, count_o matches the model, and no beats are accepted while ready_o=0.
